// File: rtl/time_keeper_pkg.sv
// Shared clock constants: BCD field limits and HH:MM word layout, plus the
// load-value validity check used wherever a HH:MM word is accepted.
package time_keeper_pkg;

  localparam logic [7:0] SEC_MAX  = 8'h59;
  localparam logic [7:0] MIN_MAX  = 8'h59;
  localparam logic [7:0] HOUR_MAX = 8'h23;

  localparam int HOUR_MSB = 15;
  localparam int HOUR_LSB = 8;
  localparam int MIN_MSB  = 7;
  localparam int MIN_LSB  = 0;

  // Tens digits are range-checked tighter than 9, so only units need the BCD check.
  function automatic logic hhmm_valid(input logic [15:0] v);
    logic digits_ok;
    logic hour_ok;
    digits_ok = (v[15:12] <= 4'd2) && (v[11:8] <= 4'd9) &&
                (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9);
    hour_ok   = (v[15:12] != 4'd2) || (v[11:8] <= 4'd3);
    return digits_ok && hour_ok;
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter 00..MAX with load priority and a same-cycle carry
// so cascaded stages roll over on the same edge.
module bcd_mod_counter #(
  parameter logic [7:0] MAX = 8'h59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] value,
  output logic       carry
);

  logic [7:0] value_r;
  logic [7:0] next_s;

  // Next BCD value and rollover carry.
  always_comb begin
    carry = inc && !load && (value_r == MAX);
    if (value_r == MAX) begin
      next_s = 8'h00;
    end else if (value_r[3:0] == 4'd9) begin
      next_s = {value_r[7:4] + 4'd1, 4'd0};
    end else begin
      next_s = {value_r[7:4], value_r[3:0] + 4'd1};
    end
  end

  // Digit register: load beats increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_r <= 8'h00;
    end else if (load) begin
      value_r <= load_val;
    end else if (inc) begin
      value_r <= next_s;
    end else begin
      value_r <= value_r;
    end
  end

  assign value = value_r;

endmodule

// File: rtl/time_keeper.sv
// BCD HH:MM:SS time base: prescaler, validated HH:MM load and the
// seconds/minutes/hours counter chain with registered event pulses.
module time_keeper
  import time_keeper_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [15:0] data_in,
  input  logic        data_in_vld,
  output logic [15:0] time_out,
  output logic [7:0]  sec_out,
  output logic        tick_1s,
  output logic        day_wrap,
  output logic        load_err
);

  localparam int PW = $clog2(CLK_FREQ);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_FREQ - 1);

  logic [PW-1:0] presc_r;
  logic          load_ok_s;
  logic          load_bad_s;
  logic          wrap_s;
  logic          advance_s;
  logic [7:0]    sec_s;
  logic [7:0]    min_s;
  logic [7:0]    hour_s;
  logic          sec_carry_s;
  logic          min_carry_s;
  logic          hour_carry_s;

  // A valid load discards a coincident advance; an invalid one does not.
  always_comb begin
    load_ok_s  = data_in_vld && hhmm_valid(data_in);
    load_bad_s = data_in_vld && !hhmm_valid(data_in);
    wrap_s     = run && (presc_r == PRESC_LAST);
    advance_s  = wrap_s && !load_ok_s;
  end

  // Prescaler: restarts on valid load, wraps at CLK_FREQ-1, holds when stopped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_r <= '0;
    end else if (load_ok_s || wrap_s) begin
      presc_r <= '0;
    end else if (run) begin
      presc_r <= presc_r + PW'(1);
    end else begin
      presc_r <= presc_r;
    end
  end

  bcd_mod_counter #(.MAX(SEC_MAX)) u_sec (
    .clk      (clk),
    .rst      (rst),
    .inc      (advance_s),
    .load     (load_ok_s),
    .load_val (8'h00),
    .value    (sec_s),
    .carry    (sec_carry_s)
  );

  bcd_mod_counter #(.MAX(MIN_MAX)) u_min (
    .clk      (clk),
    .rst      (rst),
    .inc      (sec_carry_s),
    .load     (load_ok_s),
    .load_val (data_in[MIN_MSB:MIN_LSB]),
    .value    (min_s),
    .carry    (min_carry_s)
  );

  bcd_mod_counter #(.MAX(HOUR_MAX)) u_hour (
    .clk      (clk),
    .rst      (rst),
    .inc      (min_carry_s),
    .load     (load_ok_s),
    .load_val (data_in[HOUR_MSB:HOUR_LSB]),
    .value    (hour_s),
    .carry    (hour_carry_s)
  );

  // Event pulses, aligned with the counter update they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_1s  <= 1'b0;
      day_wrap <= 1'b0;
      load_err <= 1'b0;
    end else begin
      tick_1s  <= advance_s;
      day_wrap <= hour_carry_s;
      load_err <= load_bad_s;
    end
  end

  assign time_out = {hour_s, min_s};
  assign sec_out  = sec_s;

endmodule

// File: doc/time_keeper.md
# time_keeper

Real-time BCD time base for the digital clock, on the receiving side of the keyboard controller's `data_out`/`data_out_vld` interface. It accepts a committed HH:MM value, validates it and loads it. It then counts seconds, minutes and hours from a prescaled system clock. Its `time_out` feeds back into the keyboard controller's `data_in` and into the display path.

## Interface
- `CLK_FREQ`, default 50_000_000: system clock cycles per second; the prescaler modulus. Minimum 2.
- `clk` input 1: system clock; all logic on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `run` input 1: 1 = time advances; 0 = prescaler and time frozen.
- `data_in` input 16: HH:MM as four BCD digits, `[15:12]` hour tens … `[3:0]` minute units.
- `data_in_vld` input 1: single-cycle strobe; `data_in` is sampled on the edge where it is high.
- `time_out` output 16: current HH:MM, BCD, same packing as `data_in`.
- `sec_out` output 8: current seconds, BCD `[7:4]` tens, `[3:0]` units.
- `tick_1s` output 1: one-cycle pulse on every seconds advance.
- `day_wrap` output 1: one-cycle pulse when 23:59:59 advances to 00:00:00.
- `load_err` output 1: one-cycle pulse when a strobed value is rejected.

## Operation
- Reset values:
  - `time_out` = 16'h0000, `sec_out` = 8'h00.
  - `tick_1s`, `day_wrap`, `load_err` = 0.
  - Prescaler = 0.
- Prescaler:
  - Counts 0..CLK_FREQ-1 while `run` = 1 and wraps to 0.
  - The wrap cycle is the advance event.
  - Holds its value while `run` = 0.
- Advance event:
  - Seconds increment BCD 00..59; 59 rolls to 00 and carries into minutes.
  - Minutes increment 00..59; 59 rolls to 00 and carries into hours.
  - Hours increment 00..23; 23 rolls to 00 and asserts `day_wrap`.
  - Unit digit 9 rolls to 0 with a tens increment; no binary intermediate values ever appear on outputs.
- Load validation: the value is valid iff all of the following hold:
  - every nibble ≤ 9,
  - hour tens ≤ 2,
  - hours ≤ 23 (hour tens = 2 requires hour units ≤ 3),
  - minute tens ≤ 5.
- Valid load:
  - `time_out` ← `data_in`.
  - Seconds ← 00, prescaler ← 0.
  - No `tick_1s` or `day_wrap` that cycle.
- Invalid load: time and prescaler unchanged; `load_err` pulses.
- A load is accepted regardless of `run`.
- Load and advance in the same cycle:
  - The load wins and the advance is discarded.
  - `tick_1s` is not asserted for a valid load.
  - For an invalid load the advance proceeds normally and `load_err` also pulses.
- Reset mid-count: all state clears immediately; counting resumes from 00:00:00 with the prescaler at 0 after `rst` deasserts.

## Timing
- All outputs are registered.
- Load latency: `data_in_vld` high on edge N → `time_out` = `data_in` and `sec_out` = 00 visible after edge N; `load_err` high for exactly the cycle after edge N.
- First advance after a valid load occurs CLK_FREQ running cycles after the load edge.
- `tick_1s` and `day_wrap` are high in the same cycle that the new time appears on `time_out`/`sec_out`.
- The period between consecutive `tick_1s` pulses is exactly CLK_FREQ cycles while `run` stays high; frozen cycles extend it one for one.
- No back-pressure: every strobe is consumed. Back-to-back strobes on consecutive cycles are each evaluated; the last valid one determines the state.

## Structure
- Shared clock package: BCD limit constants (SEC_MAX = 8'h59, MIN_MAX = 8'h59, HOUR_MAX = 8'h23) and field positions within the 16-bit HH:MM word. The keyboard and display blocks use the same constants.
- Sub-module `bcd_mod_counter`, parameterized by a 2-digit BCD maximum:
  - Inputs: `inc`, `load`, `load_val`.
  - Outputs: 8-bit BCD value and a `carry` pulse that fires on rollover.
  - Instantiated three times: seconds (59), minutes (59), hours (23).
- `time_keeper` holds the prescaler, the validation logic and the output pulse registers.

## Test plan
All scenarios use `CLK_FREQ` = 4.
- Reset then `run` = 1 for 240 cycles → 60 `tick_1s` pulses, each 4 cycles apart; `time_out` = 16'h0001, `sec_out` = 8'h00.
- Load 16'h2359, then run 240 cycles → `day_wrap` pulses once, coincident with `time_out` = 16'h0000 and `sec_out` = 8'h00.
- Strobe 16'h2460, then 16'h1A05, then 16'h0960 → three `load_err` pulses; time unchanged throughout.
- Strobe 16'h1234 on the same edge as a prescaler wrap → `time_out` = 16'h1234, `sec_out` = 00, no `tick_1s`; the next tick arrives 4 cycles later.
- `run` = 0 for 100 cycles mid-count → no ticks and all outputs stable; counting resumes at the held prescaler phase.
- Assert `rst` asynchronously mid-cycle while showing 08:15:37 → all outputs at reset values before the next edge; the next tick arrives 4 cycles after release.
